// File: rtl/snake_pkg.sv
// Shared types and constants for the snake score counter.
//   state_t    : controller states (IDLE / ADD / HISCORE)
//   BCD_MAX    : saturation value of the packed 4-digit BCD score
//   BCD_ZERO   : cleared score value
//   NUM_DIGITS : number of BCD digits processed by the serial adder
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADD     = 2'd1,
    ST_HISCORE = 2'd2
  } state_t;

  localparam logic [15:0] BCD_MAX    = 16'h9999;
  localparam logic [15:0] BCD_ZERO   = 16'h0000;
  localparam int          NUM_DIGITS = 4;

endpackage

// File: rtl/snake_bcd_digit_add.sv
// Single-digit BCD adder, purely combinational.
//   digit_a   : input BCD digit (0..9)
//   addend    : BCD digit to add (0..9)
//   carry_in  : carry from the lower digit
//   digit_sum : resulting BCD digit
//   carry_out : decimal carry into the next digit
module snake_bcd_digit_add (
  input  logic [3:0] digit_a,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] digit_sum,
  output logic       carry_out
);

  logic [4:0] raw_sum;
  logic [4:0] adj_sum;

  always_comb begin
    raw_sum = {1'b0, digit_a} + {1'b0, addend} + {4'b0000, carry_in};
    adj_sum = raw_sum - 5'd10;
    // Maximum raw sum is 9+9+1 = 19, so one subtraction of ten suffices.
    if (raw_sum > 5'd9) begin
      digit_sum = adj_sum[3:0];
      carry_out = 1'b1;
    end else begin
      digit_sum = raw_sum[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/snake_score_counter.sv
// Running score and session high score for the snake game, packed 4-digit BCD.
// Each eat pulse adds POINTS through a digit-serial adder (one digit per
// cycle), so o_Score only changes when a whole add commits. Eats arriving
// while busy are queued in a small pending counter.
//   i_Clk        : system clock
//   i_Reset      : synchronous active-high reset, clears everything
//   i_Eat        : one-cycle pulse, add POINTS
//   i_Clear      : new-game pulse, clears score and queue, keeps high score
//   o_Score      : committed score (packed BCD)
//   o_HighScore  : highest committed score since reset (packed BCD)
//   o_Busy       : controller not idle
//   o_Saturated  : o_Score is 9999
//   o_Dropped    : one-cycle pulse when an eat is lost to a full queue
module snake_score_counter
  import snake_pkg::*;
#(
  parameter int         SCORE_WIDTH   = 16,
  parameter logic [7:0] POINTS        = 8'h01,
  parameter int         PENDING_WIDTH = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Eat,
  input  logic                   i_Clear,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic [SCORE_WIDTH-1:0] o_HighScore,
  output logic                   o_Busy,
  output logic                   o_Saturated,
  output logic                   o_Dropped
);

  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

  state_t                   state_q, state_d;
  logic [SCORE_WIDTH-1:0]   work_q;
  logic [1:0]               digit_idx_q;
  logic                     carry_q;
  logic [PENDING_WIDTH-1:0] pending_q;
  logic [SCORE_WIDTH-1:0]   score_q;
  logic [SCORE_WIDTH-1:0]   high_q;
  logic                     sat_q;
  logic                     drop_q;

  // Controller decisions
  logic start_add;
  logic commit;
  logic pend_inc;
  logic pend_dec;
  logic drop;

  // Shared digit adder datapath
  logic [3:0]             digit_base;
  logic [3:0]             work_digit;
  logic [3:0]             addend;
  logic [3:0]             sum_digit;
  logic                   carry_out;
  logic [SCORE_WIDTH-1:0] commit_value;

  assign digit_base = {digit_idx_q, 2'b00};
  assign work_digit = work_q[digit_base +: 4];

  always_comb begin
    case (digit_idx_q)
      2'd0:    addend = POINTS[3:0];
      2'd1:    addend = POINTS[7:4];
      default: addend = 4'd0;
    endcase
  end

  snake_bcd_digit_add u_digit_add (
    .digit_a   (work_digit),
    .addend    (addend),
    .carry_in  (carry_q),
    .digit_sum (sum_digit),
    .carry_out (carry_out)
  );

  // A carry out of the thousands digit means the true sum exceeds 9999.
  assign commit_value = carry_out ? BCD_MAX : {sum_digit, work_q[SCORE_WIDTH-5:0]};

  wire pending_full = (pending_q == {PENDING_WIDTH{1'b1}});

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    start_add = 1'b0;
    commit    = 1'b0;
    pend_inc  = 1'b0;
    pend_dec  = 1'b0;
    drop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Eat) begin
          state_d   = ST_ADD;
          start_add = 1'b1;
        end
      end
      ST_ADD: begin
        pend_inc = i_Eat && !pending_full;
        drop     = i_Eat && pending_full;
        if (digit_idx_q == LAST_DIGIT) begin
          commit  = 1'b1;
          state_d = ST_HISCORE;
        end
      end
      ST_HISCORE: begin
        // An eat arriving here is consumed by the restart directly, which is
        // the same as queueing it and dequeuing one entry in the same cycle.
        if (i_Eat || pending_q != '0) begin
          state_d   = ST_ADD;
          start_add = 1'b1;
          pend_dec  = !i_Eat;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other, like real flops.
    if (i_Reset || i_Clear) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      work_q      <= BCD_ZERO;
      digit_idx_q <= 2'd0;
      carry_q     <= 1'b0;
      pending_q   <= '0;
      score_q     <= BCD_ZERO;
      high_q      <= BCD_ZERO;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else if (i_Clear) begin
      work_q      <= BCD_ZERO;
      digit_idx_q <= 2'd0;
      carry_q     <= 1'b0;
      pending_q   <= '0;
      score_q     <= BCD_ZERO;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= drop;

      if (start_add) begin
        work_q      <= score_q;
        digit_idx_q <= 2'd0;
        carry_q     <= 1'b0;
      end else if (state_q == ST_ADD) begin
        work_q[digit_base +: 4] <= sum_digit;
        carry_q                 <= carry_out;
        digit_idx_q             <= digit_idx_q + 2'd1;
      end

      if (commit) begin
        score_q <= commit_value;
        sat_q   <= (commit_value == BCD_MAX);
      end

      // Packed BCD orders the same way as unsigned binary.
      if (state_q == ST_HISCORE && score_q > high_q) high_q <= score_q;

      if (pend_inc)      pending_q <= pending_q + 1'b1;
      else if (pend_dec) pending_q <= pending_q - 1'b1;
    end
  end

  assign o_Score     = score_q;
  assign o_HighScore = high_q;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Saturated = sat_q;
  assign o_Dropped   = drop_q;

endmodule

// File: tb/tb_snake_score_counter.sv
// Self-checking bench for snake_score_counter. Two instances (1 point and
// 50 points per eat) share one stimulus stream; a decimal, cycle-count based
// model of each predicts all outputs after every clock edge.
module tb_snake_score_counter;

  logic i_Clk = 1'b0;
  logic i_Reset, i_Eat, i_Clear;

  logic [15:0] score_a, high_a, score_b, high_b;
  logic        busy_a, sat_a, drop_a, busy_b, sat_b, drop_b;

  always #5 i_Clk = ~i_Clk;

  snake_score_counter #(.SCORE_WIDTH(16), .POINTS(8'h01), .PENDING_WIDTH(3)) u_dut_a (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Eat       (i_Eat),
    .i_Clear     (i_Clear),
    .o_Score     (score_a),
    .o_HighScore (high_a),
    .o_Busy      (busy_a),
    .o_Saturated (sat_a),
    .o_Dropped   (drop_a)
  );

  snake_score_counter #(.SCORE_WIDTH(16), .POINTS(8'h50), .PENDING_WIDTH(3)) u_dut_b (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Eat       (i_Eat),
    .i_Clear     (i_Clear),
    .o_Score     (score_b),
    .o_HighScore (high_b),
    .o_Busy      (busy_b),
    .o_Saturated (sat_b),
    .o_Dropped   (drop_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: decimal score, and a phase counter for the add in flight
  // (0 = idle, 1..4 = digit cycles, 5 = high-score cycle).
  int m_pts   [2] = '{1, 50};
  int m_score [2];
  int m_high  [2];
  int m_pend  [2];
  int m_phase [2];
  bit m_drop  [2];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit eat, input bit clr, input bit rst);
    for (int i = 0; i < 2; i++) begin
      if (rst || clr) begin
        m_score[i] = 0;
        if (rst) m_high[i] = 0;
        m_pend[i]  = 0;
        m_phase[i] = 0;
        m_drop[i]  = 1'b0;
      end else begin
        m_drop[i] = 1'b0;
        if (m_phase[i] == 0) begin
          if (eat) m_phase[i] = 1;
        end else if (m_phase[i] < 5) begin
          if (eat) begin
            if (m_pend[i] < 7) m_pend[i]++;
            else m_drop[i] = 1'b1;
          end
          if (m_phase[i] == 4) begin
            m_score[i] = m_score[i] + m_pts[i];
            if (m_score[i] > 9999) m_score[i] = 9999;
          end
          m_phase[i]++;
        end else begin
          if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
          if (eat) m_pend[i]++;
          if (m_pend[i] > 0) begin
            m_pend[i]--;
            m_phase[i] = 1;
          end else begin
            m_phase[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("score_a", score_a, to_bcd(m_score[0]));
    check("high_a",  high_a,  to_bcd(m_high[0]));
    check("busy_a",  {15'd0, busy_a}, {15'd0, m_phase[0] != 0});
    check("sat_a",   {15'd0, sat_a},  {15'd0, m_score[0] == 9999});
    check("drop_a",  {15'd0, drop_a}, {15'd0, m_drop[0]});
    check("score_b", score_b, to_bcd(m_score[1]));
    check("high_b",  high_b,  to_bcd(m_high[1]));
    check("busy_b",  {15'd0, busy_b}, {15'd0, m_phase[1] != 0});
    check("sat_b",   {15'd0, sat_b},  {15'd0, m_score[1] == 9999});
    check("drop_b",  {15'd0, drop_b}, {15'd0, m_drop[1]});
  endtask

  // Inputs change just after a falling edge; outputs are checked on the next
  // falling edge, half a period after the rising edge that produced them.
  task automatic tick(input bit eat, input bit clr, input bit rst);
    i_Eat   = eat;
    i_Clear = clr;
    i_Reset = rst;
    @(posedge i_Clk);
    model_step(eat, clr, rst);
    @(negedge i_Clk);
    compare_all();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy_a; n++) tick(1'b0, 1'b0, 1'b0);
    check("idle_wait", {15'd0, busy_a}, 16'd0);
  endtask

  task automatic eat_and_wait();
    tick(1'b1, 1'b0, 1'b0);
    wait_idle();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Eat = 1'b0; i_Clear = 1'b0; i_Reset = 1'b1;
    @(negedge i_Clk);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_score", score_a, 16'h0000);

    // Single eat: 4 digit cycles, commit, then high-score update.
    eat_and_wait();
    check("first_score", score_a, 16'h0001);
    check("first_high",  high_a,  16'h0001);

    // Reach 0099, then one more to ripple a carry into the hundreds.
    repeat (99) eat_and_wait();
    check("carry_0100", score_a, 16'h0100);
    check("pts50_5000", score_b, 16'h5000);

    // Drive the 50-point instance to 9950, then into saturation.
    repeat (99) eat_and_wait();
    check("pts50_9950", score_b, 16'h9950);
    eat_and_wait();
    check("sat_9999", score_b, 16'h9999);
    check("sat_flag", {15'd0, sat_b}, 16'd1);
    eat_and_wait();
    check("sat_hold", score_b, 16'h9999);

    // Four consecutive eats from idle: three queue behind the first.
    tick(1'b0, 1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_idle();
    check("burst4", score_a, 16'h0004);

    // Ten consecutive eats: the queue overflows once.
    tick(1'b0, 1'b1, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    wait_idle();

    // Clear mid-add with a same-cycle eat.
    tick(1'b0, 1'b0, 1'b1);
    repeat (12) eat_and_wait();
    check("pre_clear", score_a, 16'h0012);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("clr_score", score_a, 16'h0000);
    check("clr_high",  high_a,  16'h0012);
    tick(1'b0, 1'b0, 1'b0);
    check("clr_idle", {15'd0, busy_a}, 16'd0);
    repeat (3) eat_and_wait();
    check("high_kept", high_a, 16'h0012);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_high", high_a, 16'h0000);

    // Random eats with occasional clears.
    repeat (400) tick($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
